// File: rtl/quad_pkg.sv
// quad_pkg: shared defaults and A/B bit positions for the quadrature input filter.
package quad_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_W_DEF = 8;
  localparam int A_BIT = 0;
  localparam int B_BIT = 1;
endpackage

// File: rtl/quad_bit_filter.sv
// quad_bit_filter: synchroniser chain plus stability counter for one raw input bit.
module quad_bit_filter import quad_pkg::*; #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_raw,
  input  logic [FILT_W-1:0] filt_len,
  output logic              out_q,
  output logic              chg_q,
  output logic              chg_d
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0] cnt_q, cnt_d, len;
  logic [FILT_W:0] cnt_inc;
  logic out_d, s;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
    s = sync_q[SYNC_STAGES-1];
    len = (filt_len == '0) ? FILT_W'(1) : filt_len;
    cnt_inc = {1'b0, cnt_q} + (FILT_W+1)'(1);
    chg_d = (s != out_q) && (cnt_inc >= {1'b0, len});
    out_d = chg_d ? s : out_q;
    // saturate rather than wrap so a long pending run is never forgotten
    cnt_d = (s == out_q || chg_d) ? '0 : (&cnt_q) ? cnt_q : cnt_inc[FILT_W-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      chg_q <= chg_d;
    end
  end
endmodule

// File: rtl/quad_input_filter.sv
// quad_input_filter: per-bit glitch filtering of N_ENC quadrature pairs with
// change strobes and a per-encoder simultaneous A/B transition flag.
module quad_input_filter import quad_pkg::*; #(
  parameter int N_ENC = 1,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W = FILT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_ENC-1:0]   inQ,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic                 err_clr,
  output logic [2*N_ENC-1:0]   outQ,
  output logic [2*N_ENC-1:0]   chg,
  output logic [N_ENC-1:0]     err,
  output logic [N_ENC-1:0]     err_flag
);
  logic [2*N_ENC-1:0] chg_d;
  logic [N_ENC-1:0] err_d, err_q, err_flag_d, err_flag_q;
  genvar i;
  for (i = 0; i < 2*N_ENC; i++) begin : g_bit
    quad_bit_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_bit (
      .clk(clk),
      .rst(rst),
      .in_raw(inQ[i]),
      .filt_len(filt_len),
      .out_q(outQ[i]),
      .chg_q(chg[i]),
      .chg_d(chg_d[i])
    );
  end
  // err uses next-state strobes so it lines up with the outQ update
  always_comb begin
    err_d = '0;
    for (int k = 0; k < N_ENC; k++) err_d[k] = chg_d[2*k+A_BIT] & chg_d[2*k+B_BIT];
    err_flag_d = err_d | (err_flag_q & {N_ENC{~err_clr}});
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      err_flag_q <= '0;
    end else begin
      err_q <= err_d;
      err_flag_q <= err_flag_d;
    end
  end
  assign err = err_q;
  assign err_flag = err_flag_q;
endmodule

// File: tb/tb_quad_input_filter.sv
// tb_quad_input_filter: scoreboard bench for a two-encoder quad_input_filter.
module tb_quad_input_filter;
  localparam int N_ENC = 2;
  localparam int SS = 2;
  localparam int FW = 8;
  localparam int NB = 2*N_ENC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic [NB-1:0] inQ = 4'b0011;
  logic [FW-1:0] filt_len = 8'd3;
  logic [NB-1:0] outQ, chg;
  logic [N_ENC-1:0] err, err_flag;
  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] c;
    logic [1:0] e;
    logic [1:0] f;
  } exp_t;
  exp_t sb[$];

  logic [SS-1:0] sh_m [NB];
  int run_m [NB];
  logic [NB-1:0] out_m;
  logic [N_ENC-1:0] flag_m;

  always #5 clk = ~clk;

  quad_input_filter #(.N_ENC(N_ENC), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk(clk),
    .rst(rst),
    .inQ(inQ),
    .filt_len(filt_len),
    .err_clr(err_clr),
    .outQ(outQ),
    .chg(chg),
    .err(err),
    .err_flag(err_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lat(input int idx, input logic val, input int exp, input string tag);
    int n = 0;
    while (outQ[idx] !== val && n < 50) begin
      cyc(1);
      n++;
    end
    check(tag, n, exp);
  endtask

  // Reference model: delay line per bit, run counter against the accepted level
  always @(posedge clk or posedge rst) begin : model
    exp_t x;
    int len;
    logic s;
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        sh_m[b] = '0;
        run_m[b] = 0;
      end
      out_m = '0;
      flag_m = '0;
      sb.delete();
    end else begin
      len = (filt_len == 0) ? 1 : int'(filt_len);
      x = '0;
      for (int b = 0; b < NB; b++) begin
        s = sh_m[b][SS-1];
        sh_m[b] = {sh_m[b][SS-2:0], inQ[b]};
        if (s == out_m[b]) run_m[b] = 0;
        else if (run_m[b] + 1 >= len) begin
          out_m[b] = s;
          x.c[b] = 1'b1;
          run_m[b] = 0;
        end else if (run_m[b] < 255) run_m[b]++;
      end
      x.o = out_m;
      x.e = {x.c[3] & x.c[2], x.c[1] & x.c[0]};
      flag_m = x.e | (flag_m & ~{N_ENC{err_clr}});
      x.f = flag_m;
      sb.push_back(x);
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t x;
    if (rst) begin
      check("rst_outQ", outQ, 0);
      check("rst_chg", chg, 0);
      check("rst_err", err, 0);
      check("rst_flag", err_flag, 0);
    end else if (sb.size() > 0) begin
      x = sb.pop_front();
      check("sb_outQ", outQ, x.o);
      check("sb_chg", chg, x.c);
      check("sb_err", err, x.e);
      check("sb_flag", err_flag, x.f);
    end
  end

  initial begin
    logic [1:0] seq [6];
    logic [1:0] prev;
    int idx;
    seq = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    cyc(3);
    rst = 1'b0;
    lat(0, 1'b1, 5, "lat_after_reset");
    check("rel_outQ", outQ[1:0], 2'b11);
    check("rel_chg", chg[1:0], 2'b11);
    check("rel_err", err[0], 1);
    cyc(1);
    check("rel_chg_off", chg[1:0], 0);
    check("rel_err_off", err[0], 0);
    check("rel_flag_sticky", err_flag[0], 1);

    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    filt_len = 8'd4;
    prev = 2'b11;
    for (int j = 0; j < 6; j++) begin
      idx = ((seq[j] ^ prev) == 2'b01) ? 0 : 1;
      inQ[1:0] = seq[j];
      lat(idx, seq[j][idx], 6, "lat_quad");
      cyc(4);
      prev = seq[j];
    end
    check("quad_flag", err_flag[0], 0);

    inQ[0] = 1'b1;
    cyc(3);
    inQ[0] = 1'b0;
    cyc(12);
    check("glitch3_hold", outQ[0], 0);
    inQ[0] = 1'b1;
    cyc(4);
    inQ[0] = 1'b0;
    lat(0, 1'b1, 2, "glitch4_accept");
    lat(0, 1'b0, 4, "glitch4_fall");
    cyc(3);

    filt_len = 8'd10;
    inQ[0] = 1'b1;
    cyc(7);
    check("live_before", outQ[0], 0);
    filt_len = 8'd3;
    cyc(1);
    check("live_after", outQ[0], 1);
    check("live_chg", chg[0], 1);
    filt_len = 8'd2;
    inQ[0] = 1'b0;
    lat(0, 1'b0, 4, "live_fall");
    cyc(2);

    inQ[1:0] = 2'b11;
    lat(0, 1'b1, 4, "lat_err");
    check("err_pulse", err[0], 1);
    check("err_flag_set", err_flag[0], 1);
    cyc(1);
    check("err_pulse_off", err[0], 0);
    check("err_flag_hold", err_flag[0], 1);
    inQ[1:0] = 2'b00;
    cyc(3);
    err_clr = 1'b1;
    cyc(1);
    check("err_clr_coincide_err", err[0], 1);
    check("err_clr_coincide_flag", err_flag[0], 1);
    err_clr = 1'b0;
    cyc(2);
    check("err_flag_after_coincide", err_flag[0], 1);
    err_clr = 1'b1;
    cyc(1);
    check("err_flag_cleared", err_flag[0], 0);
    err_clr = 1'b0;

    inQ[2] = 1'b1;
    lat(2, 1'b1, 4, "lat_enc1_a");
    check("enc0_static", outQ[1:0], 0);
    inQ[3] = 1'b1;
    lat(3, 1'b1, 4, "lat_enc1_b");
    inQ[3:2] = 2'b00;
    lat(2, 1'b0, 4, "lat_enc1_both");
    check("enc1_err", err, 2'b10);
    cyc(1);
    check("enc1_flag", err_flag, 2'b10);

    inQ[2] = 1'b1;
    lat(2, 1'b1, 4, "lat_enc1_pre_rst");
    filt_len = 8'd10;
    inQ[3] = 1'b1;
    cyc(5);
    check("pre_rst_outQ", outQ, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outQ", outQ, 0);
    check("async_rst_chg", chg, 0);
    check("async_rst_err", err, 0);
    check("async_rst_flag", err_flag, 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
